// File: rtl/vram_arbiter.sv
// vram_arbiter: single-port video RAM arbiter.
// Scanout fetch has absolute priority with a fixed 2-cycle return latency.
// The host gets a small write FIFO and a single-outstanding read holding register.
// Reads wait for the write FIFO to drain, so host read-after-write ordering holds.
module vram_arbiter #(
  parameter int ADDR_W     = 13,
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          i_Clk,
  input  logic                          i_Rst_n,
  input  logic                          i_fetch_req,
  input  logic [ADDR_W-1:0]             i_fetch_addr,
  output logic [DATA_W-1:0]             o_fetch_data,
  output logic                          o_fetch_valid,
  input  logic                          i_wr_valid,
  output logic                          o_wr_ready,
  input  logic [ADDR_W-1:0]             i_wr_addr,
  input  logic [DATA_W-1:0]             i_wr_data,
  input  logic                          i_rd_valid,
  output logic                          o_rd_ready,
  input  logic [ADDR_W-1:0]             i_rd_addr,
  output logic [DATA_W-1:0]             o_rd_data,
  output logic                          o_rd_rvalid,
  output logic [$clog2(FIFO_DEPTH):0]   o_wr_count,
  output logic                          o_ram_en,
  output logic                          o_ram_we,
  output logic [ADDR_W-1:0]             o_ram_addr,
  output logic [DATA_W-1:0]             o_ram_wdata,
  input  logic [DATA_W-1:0]             i_ram_rdata
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);

  // Granted command encoding; the state register holds last cycle's grant.
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_FETCH = 2'd1;
  localparam logic [1:0] ST_WRITE = 2'd2;
  localparam logic [1:0] ST_READ  = 2'd3;

  // Write FIFO storage and bookkeeping
  logic [ADDR_W-1:0] fifo_addr_r [FIFO_DEPTH];
  logic [DATA_W-1:0] fifo_data_r [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_r;
  logic [PTR_W-1:0]  rd_ptr_r;
  logic [CNT_W-1:0]  count_r;

  // Handshake enables are held low until the first clock after reset release
  logic              ready_en_r;

  // Host read holding register
  logic              rd_pending_r;
  logic [ADDR_W-1:0] rd_addr_r;

  // Arbitration
  logic [1:0]        grant_s;
  logic [1:0]        state_r;
  logic              fifo_empty_s;
  logic              fifo_full_s;
  logic              push_s;
  logic              pop_s;
  logic              rd_accept_s;

  // RAM command port registers
  logic              ram_en_r;
  logic              ram_we_r;
  logic [ADDR_W-1:0] ram_addr_r;
  logic [DATA_W-1:0] ram_wdata_r;

  // Return-path tracking: which requester owns the RAM data this cycle
  logic              ret_fetch_r;
  logic              ret_rd_r;
  logic [DATA_W-1:0] rd_data_r;

  assign fifo_empty_s = (count_r == CNT_ZERO);
  assign fifo_full_s  = (count_r == CNT_FULL);

  // Ready depends only on registered state, never on a same-cycle pop.
  assign o_wr_ready   = ready_en_r & ~fifo_full_s;
  assign o_rd_ready   = ready_en_r & ~rd_pending_r;

  assign push_s       = i_wr_valid & o_wr_ready;
  assign rd_accept_s  = i_rd_valid & o_rd_ready;
  assign pop_s        = (grant_s == ST_WRITE);

  // Fixed-priority grant: fetch, then queued writes, then a read once writes drained
  always_comb begin
    grant_s = ST_IDLE;
    if (i_fetch_req) begin
      grant_s = ST_FETCH;
    end else if (!fifo_empty_s) begin
      grant_s = ST_WRITE;
    end else if (rd_pending_r) begin
      grant_s = ST_READ;
    end else begin
      grant_s = ST_IDLE;
    end
  end

  // Ready enable: low in reset, high from the first clock after release
  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      ready_en_r <= 1'b0;
    end else begin
      ready_en_r <= 1'b1;
    end
  end

  // FIFO payload storage; contents are don't-care while empty, so no reset
  always_ff @(posedge i_Clk) begin
    if (push_s) begin
      fifo_addr_r[wr_ptr_r] <= i_wr_addr;
      fifo_data_r[wr_ptr_r] <= i_wr_data;
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally at a power-of-two depth
  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= CNT_ZERO;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CNT_ONE;
        2'b01:   count_r <= count_r - CNT_ONE;
        default: count_r <= count_r;
      endcase
    end
  end

  // Read holding register: filled on accept, freed when the read is granted
  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      rd_pending_r <= 1'b0;
      rd_addr_r    <= {ADDR_W{1'b0}};
    end else if (grant_s == ST_READ) begin
      rd_pending_r <= 1'b0;
    end else if (rd_accept_s) begin
      rd_pending_r <= 1'b1;
      rd_addr_r    <= i_rd_addr;
    end
  end

  // Register the grant and drive the RAM command port from it
  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      state_r     <= ST_IDLE;
      ram_en_r    <= 1'b0;
      ram_we_r    <= 1'b0;
      ram_addr_r  <= {ADDR_W{1'b0}};
      ram_wdata_r <= {DATA_W{1'b0}};
    end else begin
      state_r <= grant_s;
      case (grant_s)
        ST_FETCH: begin
          ram_en_r   <= 1'b1;
          ram_we_r   <= 1'b0;
          ram_addr_r <= i_fetch_addr;
        end
        ST_WRITE: begin
          ram_en_r    <= 1'b1;
          ram_we_r    <= 1'b1;
          ram_addr_r  <= fifo_addr_r[rd_ptr_r];
          ram_wdata_r <= fifo_data_r[rd_ptr_r];
        end
        ST_READ: begin
          ram_en_r   <= 1'b1;
          ram_we_r   <= 1'b0;
          ram_addr_r <= rd_addr_r;
        end
        default: begin
          // Idle: address and write data keep their last values
          ram_en_r <= 1'b0;
          ram_we_r <= 1'b0;
        end
      endcase
    end
  end

  // Mark which requester receives the RAM data arriving next cycle
  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      ret_fetch_r <= 1'b0;
      ret_rd_r    <= 1'b0;
    end else begin
      ret_fetch_r <= (state_r == ST_FETCH);
      ret_rd_r    <= (state_r == ST_READ);
    end
  end

  // Hold the last host read result between read returns
  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      rd_data_r <= {DATA_W{1'b0}};
    end else if (ret_rd_r) begin
      rd_data_r <= i_ram_rdata;
    end
  end

  // RAM data passes straight through on the return cycle to keep latency at 2
  assign o_fetch_valid = ret_fetch_r;
  assign o_fetch_data  = ret_fetch_r ? i_ram_rdata : {DATA_W{1'b0}};
  assign o_rd_rvalid   = ret_rd_r;
  assign o_rd_data     = ret_rd_r ? i_ram_rdata : rd_data_r;
  assign o_wr_count    = count_r;
  assign o_ram_en      = ram_en_r;
  assign o_ram_we      = ram_we_r;
  assign o_ram_addr    = ram_addr_r;
  assign o_ram_wdata   = ram_wdata_r;

endmodule

// File: tb/tb_vram_arbiter.sv
// Directed testbench for vram_arbiter with a behavioural 1-cycle-latency RAM.
// Unwritten RAM locations read back as the low byte of their address.
module tb_vram_arbiter;

  localparam int ADDR_W     = 13;
  localparam int DATA_W     = 8;
  localparam int FIFO_DEPTH = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              fetch_req;
  logic [ADDR_W-1:0] fetch_addr;
  logic [DATA_W-1:0] fetch_data;
  logic              fetch_valid;
  logic              wr_valid;
  logic              wr_ready;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              rd_valid;
  logic              rd_ready;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic              rd_rvalid;
  logic [2:0]        wr_count;
  logic              ram_en;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;

  bit   [DATA_W-1:0] wmem  [8192];
  bit                wflag [8192];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  vram_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .i_Clk(clk), .i_Rst_n(rst_n),
    .i_fetch_req(fetch_req), .i_fetch_addr(fetch_addr),
    .o_fetch_data(fetch_data), .o_fetch_valid(fetch_valid),
    .i_wr_valid(wr_valid), .o_wr_ready(wr_ready),
    .i_wr_addr(wr_addr), .i_wr_data(wr_data),
    .i_rd_valid(rd_valid), .o_rd_ready(rd_ready), .i_rd_addr(rd_addr),
    .o_rd_data(rd_data), .o_rd_rvalid(rd_rvalid), .o_wr_count(wr_count),
    .o_ram_en(ram_en), .o_ram_we(ram_we), .o_ram_addr(ram_addr),
    .o_ram_wdata(ram_wdata), .i_ram_rdata(ram_rdata)
  );

  // Synchronous single-port RAM model
  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_we) begin
        wmem[ram_addr]  <= ram_wdata;
        wflag[ram_addr] <= 1'b1;
      end else begin
        ram_rdata <= wflag[ram_addr] ? wmem[ram_addr] : ram_addr[7:0];
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    int cnt_exp [14];
    cnt_exp = '{0, 1, 2, 3, 4, 4, 4, 4, 3, 3, 2, 1, 0, 0};

    rst_n = 1'b0; fetch_req = 1'b0; fetch_addr = '0;
    wr_valid = 1'b0; wr_addr = '0; wr_data = '0;
    rd_valid = 1'b0; rd_addr = '0;

    // ---- Reset and idle ----
    repeat (2) @(negedge clk);
    chk("rst_wr_ready",    32'(wr_ready),    32'd0);
    chk("rst_rd_ready",    32'(rd_ready),    32'd0);
    chk("rst_ram_en",      32'(ram_en),      32'd0);
    chk("rst_ram_we",      32'(ram_we),      32'd0);
    chk("rst_ram_addr",    32'(ram_addr),    32'd0);
    chk("rst_ram_wdata",   32'(ram_wdata),   32'd0);
    chk("rst_fetch_valid", 32'(fetch_valid), 32'd0);
    chk("rst_fetch_data",  32'(fetch_data),  32'd0);
    chk("rst_rd_rvalid",   32'(rd_rvalid),   32'd0);
    chk("rst_rd_data",     32'(rd_data),     32'd0);
    chk("rst_wr_count",    32'(wr_count),    32'd0);
    rst_n = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      chk("idle_wr_ready", 32'(wr_ready), 32'd1);
      chk("idle_rd_ready", 32'(rd_ready), 32'd1);
      chk("idle_wr_count", 32'(wr_count), 32'd0);
      chk("idle_ram_en",   32'(ram_en),   32'd0);
    end

    // ---- Fetch latency: three back-to-back fetches ----
    for (int c = 0; c < 7; c++) begin
      @(negedge clk);
      chk("fetch_valid", 32'(fetch_valid), 32'((c >= 2) && (c <= 4)));
      if ((c >= 2) && (c <= 4)) begin
        chk("fetch_data", 32'(fetch_data), 32'(8'h10 + c - 2));
      end
      fetch_req  = (c < 3);
      fetch_addr = 13'(13'h010 + c);
    end

    // ---- Five writes offered while fetch is held, then fetch released ----
    for (int c = 0; c < 14; c++) begin
      @(negedge clk);
      chk("fill_wr_count", 32'(wr_count), 32'(cnt_exp[c]));
      chk("fill_wr_ready", 32'(wr_ready), 32'(cnt_exp[c] != 4));
      chk("fill_ram_we",   32'(ram_we),   32'((c >= 8) && (c <= 12)));
      if ((c >= 8) && (c <= 12)) begin
        chk("fill_ram_addr",  32'(ram_addr),  32'(13'h100 + c - 8));
        chk("fill_ram_wdata", 32'(ram_wdata), 32'(8'hA0 + c - 8));
      end
      fetch_req  = (c < 7);
      fetch_addr = 13'(13'h020 + c);
      wr_valid   = (c <= 8);
      wr_addr    = 13'(13'h100 + ((c < 4) ? c : 4));
      wr_data    = 8'(8'hA0 + ((c < 4) ? c : 4));
    end
    wr_valid = 1'b0;

    // ---- Write 0x200 then read it back ----
    @(negedge clk);
    wr_valid = 1'b1; wr_addr = 13'h200; wr_data = 8'h5A;
    @(negedge clk);
    chk("raw_rd_ready_c1", 32'(rd_ready), 32'd1);
    wr_valid = 1'b0; rd_valid = 1'b1; rd_addr = 13'h200;
    @(negedge clk);
    chk("raw_ram_we_c2",    32'(ram_we),    32'd1);
    chk("raw_ram_addr_c2",  32'(ram_addr),  32'h200);
    chk("raw_ram_wdata_c2", 32'(ram_wdata), 32'h5A);
    chk("raw_rd_ready_c2",  32'(rd_ready),  32'd0);
    chk("raw_rvalid_c2",    32'(rd_rvalid), 32'd0);
    rd_valid = 1'b0;
    @(negedge clk);
    chk("raw_ram_en_c3",   32'(ram_en),    32'd1);
    chk("raw_ram_we_c3",   32'(ram_we),    32'd0);
    chk("raw_ram_addr_c3", 32'(ram_addr),  32'h200);
    chk("raw_rd_ready_c3", 32'(rd_ready),  32'd1);
    chk("raw_rvalid_c3",   32'(rd_rvalid), 32'd0);
    @(negedge clk);
    chk("raw_rvalid_c4",   32'(rd_rvalid), 32'd1);
    chk("raw_rd_data_c4",  32'(rd_data),   32'h5A);
    @(negedge clk);
    chk("raw_rvalid_c5",   32'(rd_rvalid), 32'd0);
    chk("raw_rd_data_c5",  32'(rd_data),   32'h5A);

    // ---- Alternating fetch with two queued writes and one pending read ----
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      chk("alt_fetch_valid", 32'(fetch_valid),
          32'(((c % 2) == 0) && (c >= 2) && (c <= 10)));
      if (((c % 2) == 0) && (c >= 2) && (c <= 10)) begin
        chk("alt_fetch_data", 32'(fetch_data), 32'(8'h30 + (c - 2) / 2));
      end
      chk("alt_rvalid", 32'(rd_rvalid), 32'(c == 7));
      if (c == 7) begin
        chk("alt_rd_data", 32'(rd_data), 32'hC1);
      end
      chk("alt_ram_en", 32'(ram_en), 32'(((c >= 1) && (c <= 7)) || (c == 9)));
      chk("alt_ram_we", 32'(ram_we), 32'((c == 2) || (c == 4)));
      if ((c == 2) || (c == 4)) begin
        chk("alt_ram_addr",  32'(ram_addr),  32'(13'h300 + (c - 2) / 2));
        chk("alt_ram_wdata", 32'(ram_wdata), 32'(8'hC0 + (c - 2) / 2));
      end
      fetch_req  = ((c % 2) == 0) && (c <= 8);
      fetch_addr = 13'(13'h030 + c / 2);
      wr_valid   = (c <= 1);
      wr_addr    = 13'(13'h300 + c);
      wr_data    = 8'(8'hC0 + c);
      rd_valid   = (c == 0);
      rd_addr    = 13'h301;
    end
    fetch_req = 1'b0; wr_valid = 1'b0; rd_valid = 1'b0;

    // ---- Reset while a fetch and a read are in flight ----
    @(negedge clk);
    fetch_req = 1'b1; fetch_addr = 13'h040;
    rd_valid  = 1'b1; rd_addr    = 13'h041;
    wr_valid  = 1'b1; wr_addr    = 13'h500; wr_data = 8'hEE;
    @(negedge clk);
    chk("mid_ram_en_before",   32'(ram_en),   32'd1);
    chk("mid_ram_addr_before", 32'(ram_addr), 32'h040);
    chk("mid_wr_count_before", 32'(wr_count), 32'd1);
    fetch_req = 1'b0; rd_valid = 1'b0; wr_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("mid_ram_en_rst",  32'(ram_en),   32'd0);
    chk("mid_wr_ready_rst", 32'(wr_ready), 32'd0);
    chk("mid_rd_ready_rst", 32'(rd_ready), 32'd0);
    chk("mid_rd_data_rst",  32'(rd_data),  32'd0);
    chk("mid_wr_count_rst", 32'(wr_count), 32'd0);
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      chk("mid_fetch_valid_rst", 32'(fetch_valid), 32'd0);
      chk("mid_rvalid_rst",      32'(rd_rvalid),   32'd0);
    end
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("post_fetch_valid", 32'(fetch_valid), 32'd0);
      chk("post_rvalid",      32'(rd_rvalid),   32'd0);
      chk("post_wr_count",    32'(wr_count),    32'd0);
      chk("post_ram_en",      32'(ram_en),      32'd0);
      chk("post_wr_ready",    32'(wr_ready),    32'd1);
      chk("post_rd_ready",    32'(rd_ready),    32'd1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/vram_arbiter.md
Name: vram_arbiter

Overview:
- Arbitrates a single-port synchronous video RAM between two requesters.
- The VGA scanout fetch path has absolute priority and a fixed latency.
- A host port performs buffered writes through a small FIFO and single-outstanding reads.
- Sits between the VGA timing/pixel pipeline and the tile/frame RAM, so the host can update the screen without tearing the fetch schedule.

Parameters:
- ADDR_W, 13, RAM address width (80x60 tile map = 4800 cells).
- DATA_W, 8, RAM data width.
- FIFO_DEPTH, 4, host write FIFO entries; power of two, at least 2.

Ports:
- i_Clk  in  1  pixel clock
- i_Rst_n  in  1  asynchronous active-low reset
- i_fetch_req  in  1  scanout read request, one cycle per address
- i_fetch_addr  in  ADDR_W  scanout read address
- o_fetch_data  out  DATA_W  scanout read data
- o_fetch_valid  out  1  o_fetch_data valid, exactly 2 cycles after i_fetch_req
- i_wr_valid  in  1  host write offered
- o_wr_ready  out  1  FIFO can accept a write
- i_wr_addr  in  ADDR_W  host write address
- i_wr_data  in  DATA_W  host write data
- i_rd_valid  in  1  host read offered
- o_rd_ready  out  1  read holding register free
- i_rd_addr  in  ADDR_W  host read address
- o_rd_data  out  DATA_W  host read data
- o_rd_rvalid  out  1  one-cycle pulse, o_rd_data valid
- o_wr_count  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy
- o_ram_en  out  1  RAM command enable
- o_ram_we  out  1  RAM write enable
- o_ram_addr  out  ADDR_W  RAM address
- o_ram_wdata  out  DATA_W  RAM write data
- i_ram_rdata  in  DATA_W  RAM read data, valid 1 cycle after a read command

Behaviour:
- Reset (async assert, sync release): all outputs 0, FIFO empty, read holding register empty, state IDLE. o_wr_ready and o_rd_ready are 0 while i_Rst_n is low and 1 on the first cycle after release.
- Write handshake:
  - A write is accepted on i_wr_valid & o_wr_ready.
  - o_wr_ready = !full; it is registered-independent of a same-cycle pop, so a full FIFO never accepts, even while popping.
  - o_wr_count updates the cycle after a push or pop; a simultaneous push and pop leaves it unchanged.
- Read handshake:
  - A read is accepted on i_rd_valid & o_rd_ready into a one-entry holding register; o_rd_ready = !rd_pending.
  - rd_pending clears on the cycle the read is issued to RAM.
  - o_rd_ready rises the cycle after issue, so a back-to-back read is accepted no earlier than then.
- Grant, evaluated every cycle, highest priority first:
  1. FETCH: i_fetch_req.
  2. WRITE: FIFO not empty.
  3. READ: rd_pending and FIFO empty. Reads never bypass queued writes, so read-after-write ordering is guaranteed.
  4. IDLE otherwise.
- State register holds the granted command; RAM outputs are registered from it:
  - Grant in cycle N drives o_ram_en/we/addr/wdata in cycle N+1.
  - RAM data arrives in N+2.
  - FETCH: o_fetch_valid=1 and o_fetch_data=i_ram_rdata in N+2.
  - READ: o_rd_rvalid pulses in N+2 with o_rd_data = i_ram_rdata; o_rd_data holds that value until the next read return.
  - WRITE: FIFO head pops in cycle N; o_ram_we=1 in N+1; no return.
  - IDLE: o_ram_en=0, o_ram_we=0; addr/wdata hold their last values.
- Fetch is never stalled or dropped; host traffic progresses only in cycles without i_fetch_req. Continuous fetch indefinitely starves the host; this is intended, since the host drains during blanking.
- A fetch and a queued write to the same address in the same cycle: the fetch returns the old data and the write lands the following free cycle.
- FIFO pointers wrap modulo FIFO_DEPTH; occupancy ranges 0..FIFO_DEPTH.
- Reset asserted mid-operation:
  - In-flight fetch/read returns are discarded; o_fetch_valid and o_rd_rvalid stay 0.
  - Queued writes are lost.
  - A write already on the RAM port is truncated when o_ram_we drops immediately.

Test Plan:
- Reset, then 10 idle cycles: all outputs 0 during reset; o_wr_ready=1, o_rd_ready=1, o_wr_count=0 afterwards; o_ram_en stays 0.
- Fetch pulses at addr 0x010,0x011,0x012 in cycles 0..2, with RAM preloaded at addr=k to data k[7:0] → o_fetch_valid in cycles 2..4 with data 0x10,0x11,0x12; no gaps.
- Push 5 writes (addr 0x100+i, data 0xA0+i) back-to-back with i_fetch_req held high: 4 accepted, o_wr_ready=0 while o_wr_count=4, and no RAM write occurs while fetch is held. Drop fetch → 4 writes issue on consecutive cycles in order, then the 5th is accepted and written.
- Write addr 0x200 = 0x5A, then immediately read 0x200 → read issues only after the write; o_rd_rvalid pulses once with o_rd_data=0x5A.
- Alternate i_fetch_req every other cycle with 2 queued writes and 1 pending read: writes and the read occupy only the gap cycles; fetch latency stays exactly 2; the read returns after both writes.
- Assert i_Rst_n low one cycle after a fetch and a read issue: no o_fetch_valid or o_rd_rvalid pulse; FIFO count 0 after release.
